// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: Y86-64 icodes, stat codes and access decode shared by the memory stage
package mem_stage_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;
  localparam logic [3:0] RNONE   = 4'hF;
  typedef enum logic {IDLE, ACC} state_e;
  function automatic logic is_rd(input logic [3:0] icode);
    return icode == IMRMOVQ || icode == IPOPQ || icode == IRET;
  endfunction
  function automatic logic is_wr(input logic [3:0] icode);
    return icode == IRMMOVQ || icode == IPUSHQ || icode == ICALL;
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts bus wait cycles; expired marks the last allowed cycle without ack
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt_q;
  assign expired = run && cnt_q == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= clear ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: Y86-64 memory stage over a req/ack data bus; MEM_TIMEOUT_EN adds a bus ack timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [63:0] MEM_BYTES   = 64'h10000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        e_valid_i,
  input  logic [3:0]  e_icode_i,
  input  logic [2:0]  e_stat_i,
  input  logic [63:0] e_valE_i,
  input  logic [63:0] e_valA_i,
  input  logic [3:0]  e_dstE_i,
  input  logic [3:0]  e_dstM_i,
  output logic        m_ready_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        w_valid_o,
  output logic [3:0]  w_icode_o,
  output logic [2:0]  w_stat_o,
  output logic [63:0] w_valE_o,
  output logic [63:0] w_valM_o,
  output logic [3:0]  w_dstE_o,
  output logic [3:0]  w_dstM_o,
  output logic        halted_o
);
  state_e      state_q;
  logic        req_q, we_q, w_valid_q, halted_q, m_rd_q;
  logic [63:0] addr_q, wdata_q, w_valE_q, w_valM_q, m_valE_q;
  logic [3:0]  w_icode_q, w_dstE_q, w_dstM_q, m_icode_q, m_dstE_q, m_dstM_q;
  logic [2:0]  w_stat_q, stat_d;
  logic [63:0] addr_d;
  logic        rd, wr, mem, go, timeout;
  assign rd     = is_rd(e_icode_i);
  assign wr     = is_wr(e_icode_i);
  assign mem    = rd | wr;
  assign addr_d = (e_icode_i == IPOPQ || e_icode_i == IRET) ? e_valA_i : e_valE_i;
  assign go     = e_stat_i == SAOK && mem && addr_d <= MEM_BYTES - 64'd8;
  assign stat_d = (e_stat_i == SAOK && mem) ? SADR : e_stat_i;
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state_q != ACC),
    .run     (state_q == ACC && !dmem_ack_i),
    .expired (timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      w_valid_q <= 1'b0;
      w_icode_q <= INOP;
      w_stat_q  <= SAOK;
      w_valE_q  <= '0;
      w_valM_q  <= '0;
      w_dstE_q  <= RNONE;
      w_dstM_q  <= RNONE;
      halted_q  <= 1'b0;
      m_rd_q    <= 1'b0;
      m_icode_q <= INOP;
      m_valE_q  <= '0;
      m_dstE_q  <= RNONE;
      m_dstM_q  <= RNONE;
    end else begin
      w_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (e_valid_i && !halted_q) begin
          if (go) begin
            state_q   <= ACC;
            req_q     <= 1'b1;
            we_q      <= wr;
            addr_q    <= addr_d;
            wdata_q   <= e_valA_i;
            m_rd_q    <= rd;
            m_icode_q <= e_icode_i;
            m_valE_q  <= e_valE_i;
            m_dstE_q  <= e_dstE_i;
            m_dstM_q  <= e_dstM_i;
          end else begin
            w_valid_q <= 1'b1;
            w_icode_q <= e_icode_i;
            w_stat_q  <= stat_d;
            w_valE_q  <= e_valE_i;
            w_valM_q  <= '0;
            w_dstE_q  <= e_dstE_i;
            w_dstM_q  <= e_dstM_i;
            halted_q  <= stat_d != SAOK;
          end
        end
      end else if (dmem_ack_i || timeout) begin
        state_q   <= IDLE;
        req_q     <= 1'b0;
        we_q      <= 1'b0;
        w_valid_q <= 1'b1;
        w_icode_q <= m_icode_q;
        w_stat_q  <= (dmem_ack_i && !dmem_err_i) ? SAOK : SADR;
        w_valE_q  <= m_valE_q;
        w_valM_q  <= (dmem_ack_i && m_rd_q) ? dmem_rdata_i : '0;
        w_dstE_q  <= m_dstE_q;
        w_dstM_q  <= m_dstM_q;
        halted_q  <= !dmem_ack_i || dmem_err_i;
      end
    end
  end
  assign m_ready_o    = state_q == IDLE;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign w_valid_o    = w_valid_q;
  assign w_icode_o    = w_icode_q;
  assign w_stat_o     = w_stat_q;
  assign w_valE_o     = w_valE_q;
  assign w_valM_o     = w_valM_q;
  assign w_dstE_o     = w_dstE_q;
  assign w_dstM_o     = w_dstM_q;
  assign halted_o     = halted_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, randomized model comparison and multi-cycle corner sequences
module tb_mem_stage;
  import mem_stage_pkg::*;
  localparam logic [63:0] MB = 64'h10000;
  typedef struct {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    int          wt;
    logic [63:0] rdata;
    logic        err;
    logic        x_req;
    logic        x_we;
    logic [63:0] x_addr;
    logic [2:0]  x_stat;
    logic [63:0] x_valM;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic e_valid = 1'b0, ack = 1'b0, err = 1'b0;
  logic [3:0] e_icode = INOP, e_dstE = RNONE, e_dstM = RNONE;
  logic [2:0] e_stat = SAOK;
  logic [63:0] e_valE = '0, e_valA = '0, rdata = '0;
  logic m_ready, req, we, w_valid, halted;
  logic [63:0] addr, wdata, w_valE, w_valM;
  logic [3:0] w_icode, w_dstE, w_dstM;
  logic [2:0] w_stat;
  int n_chk = 0, n_pass = 0;
  logic halted_m;
  vec_t tv [11];
  vec_t v;
  mem_stage #(.MEM_BYTES(MB), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_i(rst), .e_valid_i(e_valid), .e_icode_i(e_icode), .e_stat_i(e_stat),
    .e_valE_i(e_valE), .e_valA_i(e_valA), .e_dstE_i(e_dstE), .e_dstM_i(e_dstM),
    .m_ready_o(m_ready), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
    .dmem_wdata_o(wdata), .dmem_ack_i(ack), .dmem_rdata_i(rdata), .dmem_err_i(err),
    .w_valid_o(w_valid), .w_icode_o(w_icode), .w_stat_o(w_stat), .w_valE_o(w_valE),
    .w_valM_o(w_valM), .w_dstE_o(w_dstE), .w_dstM_o(w_dstM), .halted_o(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic do_reset();
    rst = 1'b1; e_valid = 1'b0; ack = 1'b0; err = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " req"}, req, 0);      chk({tag, " we"}, we, 0);
    chk({tag, " addr"}, addr, 0);    chk({tag, " wdata"}, wdata, 0);
    chk({tag, " w_valid"}, w_valid, 0);
    chk({tag, " w_icode"}, w_icode, INOP); chk({tag, " w_stat"}, w_stat, SAOK);
    chk({tag, " w_valE"}, w_valE, 0); chk({tag, " w_valM"}, w_valM, 0);
    chk({tag, " w_dstE"}, w_dstE, RNONE);  chk({tag, " w_dstM"}, w_dstM, RNONE);
    chk({tag, " halted"}, halted, 0); chk({tag, " ready"}, m_ready, 1);
  endtask
  // Expected results straight from the access rules: which icodes touch memory, which operand
  // is the address, and whether an 8-byte access fits below MEM_BYTES.
  function automatic vec_t model(input vec_t i);
    vec_t o = i;
    logic reads  = i.icode inside {IMRMOVQ, IPOPQ, IRET};
    logic writes = i.icode inside {IRMMOVQ, IPUSHQ, ICALL};
    logic [63:0] a = (i.icode inside {IPOPQ, IRET}) ? i.valA : i.valE;
    logic fits = ({1'b0, a} + 65'd8) <= {1'b0, MB};
    o.x_req  = i.stat == SAOK && (reads || writes) && fits;
    o.x_we   = o.x_req && writes;
    o.x_addr = a;
    if (i.stat != SAOK) o.x_stat = i.stat;
    else if ((reads || writes) && !fits) o.x_stat = SADR;
    else o.x_stat = (o.x_req && i.err) ? SADR : SAOK;
    o.x_valM = (o.x_req && reads) ? i.rdata : 64'h0;
    return o;
  endfunction
  function automatic vec_t rand_vec();
    vec_t r;
    logic [3:0] ops [8];
    logic [63:0] a;
    int k;
    ops[0] = IOPQ; ops[1] = INOP; ops[2] = IRMMOVQ; ops[3] = IMRMOVQ;
    ops[4] = IPUSHQ; ops[5] = IPOPQ; ops[6] = ICALL; ops[7] = IRET;
    r.icode = ops[$urandom_range(0, 7)];
    r.stat  = ($urandom_range(0, 15) == 0) ? SINS : SAOK;
    k = $urandom_range(0, 7);
    a = (k == 0) ? MB - 64'($urandom_range(1, 7)) :
        (k == 1) ? {32'($urandom), 32'($urandom)} : {48'h0, 13'($urandom_range(0, 8191)), 3'b000};
    r.valE  = {32'($urandom), 32'($urandom)};
    r.valA  = {32'($urandom), 32'($urandom)};
    if (r.icode == IPOPQ || r.icode == IRET) r.valA = a;
    else r.valE = a;
    r.dstE  = 4'($urandom);
    r.dstM  = 4'($urandom);
    r.wt    = $urandom_range(0, 3);
    r.rdata = {32'($urandom), 32'($urandom)};
    r.err   = $urandom_range(0, 9) == 0;
    return model(r);
  endfunction
  task automatic run_instr(input vec_t x, input logic disc);
    @(negedge clk);
    chk("ready before", m_ready, 1);
    e_valid = 1'b1; e_icode = x.icode; e_stat = x.stat; e_valE = x.valE;
    e_valA = x.valA; e_dstE = x.dstE; e_dstM = x.dstM;
    @(negedge clk);
    e_valid = 1'b0;
    if (x.x_req && !disc) begin
      for (int i = 0; i <= x.wt; i++) begin
        chk("req held", req, 1);   chk("we", we, x.x_we);
        chk("addr", addr, x.x_addr);
        if (x.x_we) chk("wdata", wdata, x.valA);
        chk("ready in acc", m_ready, 0); chk("no early w_valid", w_valid, 0);
        if (i == x.wt) begin ack = 1'b1; rdata = x.rdata; err = x.err; end
        @(negedge clk);
      end
      ack = 1'b0; err = 1'b0; rdata = {32'($urandom), 32'($urandom)};
    end
    chk("req idle", req, 0);
    chk("w_valid", w_valid, !disc);
    if (!disc) begin
      chk("w_icode", w_icode, x.icode); chk("w_stat", w_stat, x.x_stat);
      chk("w_valE", w_valE, x.valE);    chk("w_valM", w_valM, x.x_valM);
      chk("w_dstE", w_dstE, x.dstE);    chk("w_dstM", w_dstM, x.dstM);
    end
    chk("halted", halted, disc || x.x_stat != SAOK);
    @(negedge clk);
    chk("w_valid pulse", w_valid, 0);
  endtask
  initial begin
    tv[0]  = '{IOPQ,    SAOK, 64'h5,      64'h0,   4'h3, RNONE, 0, 64'h0,        1'b0, 1'b0, 1'b0, 64'h5,      SAOK, 64'h0};
    tv[1]  = '{IMRMOVQ, SAOK, 64'h100,    64'h0,   RNONE, 4'h2, 3, 64'hDEADBEEF, 1'b0, 1'b1, 1'b0, 64'h100,    SAOK, 64'hDEADBEEF};
    tv[2]  = '{IPUSHQ,  SAOK, 64'h1F8,    64'h42,  4'h4, RNONE, 1, 64'h77,       1'b0, 1'b1, 1'b1, 64'h1F8,    SAOK, 64'h0};
    tv[3]  = '{IRMMOVQ, SAOK, MB - 4,     64'h9,   RNONE, RNONE, 0, 64'h0,       1'b0, 1'b0, 1'b0, MB - 4,     SADR, 64'h0};
    tv[4]  = '{IPOPQ,   SAOK, 64'h208,    64'h200, 4'h4, 4'h1, 0, 64'h7,         1'b1, 1'b1, 1'b0, 64'h200,    SADR, 64'h7};
    tv[5]  = '{IMRMOVQ, SAOK, MB - 8,     64'h0,   RNONE, 4'h5, 2, 64'h1234,     1'b0, 1'b1, 1'b0, MB - 8,     SAOK, 64'h1234};
    tv[6]  = '{IMRMOVQ, SAOK, MB - 7,     64'h0,   RNONE, 4'h5, 0, 64'h1234,     1'b0, 1'b0, 1'b0, MB - 7,     SADR, 64'h0};
    tv[7]  = '{IRET,    SAOK, 64'h88,     64'h80,  4'h4, RNONE, 0, 64'h400,      1'b0, 1'b1, 1'b0, 64'h80,     SAOK, 64'h400};
    tv[8]  = '{ICALL,   SAOK, 64'h78,     64'h99,  4'h4, RNONE, 2, 64'h55,       1'b0, 1'b1, 1'b1, 64'h78,     SAOK, 64'h0};
    tv[9]  = '{IHALT,   SHLT, 64'h0,      64'h0,   RNONE, RNONE, 0, 64'h0,       1'b0, 1'b0, 1'b0, 64'h0,      SHLT, 64'h0};
    tv[10] = '{IMRMOVQ, SADR, 64'h10,     64'h0,   RNONE, 4'h3, 0, 64'h0,        1'b0, 1'b0, 1'b0, 64'h10,     SADR, 64'h0};
    do_reset();
    chk_reset("reset");
    for (int i = 0; i < 11; i++) begin
      do_reset();
      run_instr(tv[i], 1'b0);
    end
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      e_valid = 1'b1; e_icode = IOPQ; e_stat = SAOK; e_valE = 64'(i); e_dstE = 4'h3;
      if (i > 1) begin
        chk("b2b w_valid", w_valid, 1); chk("b2b w_valE", w_valE, 64'(i - 1));
      end
      chk("b2b ready", m_ready, 1);
    end
    @(negedge clk);
    e_valid = 1'b0;
    chk("b2b last", w_valE, 64'h3);
    ack = 1'b1; err = 1'b1; rdata = 64'hBAD;
    @(negedge clk);
    ack = 1'b0; err = 1'b0;
    chk("stray ack req", req, 0); chk("stray ack w_valid", w_valid, 0);
    chk("stray ack halted", halted, 0);
    do_reset();
    run_instr(tv[3], 1'b0);
    v = model('{IOPQ, SAOK, 64'h5, 64'h0, 4'h3, RNONE, 0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, SAOK, 64'h0});
    run_instr(v, 1'b1);
    run_instr(tv[1], 1'b1);
    chk("halted hold stat", w_stat, SADR);
    do_reset();
    @(negedge clk);
    e_valid = 1'b1; e_icode = IMRMOVQ; e_stat = SAOK; e_valE = 64'h300;
    @(negedge clk);
    e_valid = 1'b0;
    chk("pre-reset req", req, 1);
    #2 rst = 1'b1;
    #1 chk_reset("async reset");
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_TIMEOUT_EN
    begin
      int cnt = 0;
      do_reset();
      @(negedge clk);
      e_valid = 1'b1; e_icode = IMRMOVQ; e_stat = SAOK; e_valE = 64'h40;
      @(negedge clk);
      e_valid = 1'b0;
      for (int i = 0; i < 20 && !w_valid; i++) begin
        if (req) cnt++;
        @(negedge clk);
      end
      chk("timeout req cycles", 64'(cnt), 64'd4);
      chk("timeout w_valid", w_valid, 1); chk("timeout stat", w_stat, SADR);
      chk("timeout valM", w_valM, 0);     chk("timeout halted", halted, 1);
    end
`endif
    do_reset();
    halted_m = 1'b0;
    for (int n = 0; n < 80; n++) begin
      v = rand_vec();
      run_instr(v, halted_m);
      if (halted_m) begin
        do_reset();
        halted_m = 1'b0;
      end else if (v.x_stat != SAOK) halted_m = 1'b1;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
